// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Time-shares one external combinational 4x4 unsigned multiplier between two
//   requesters. IDLE arbitrates and registers the winner's operands onto
//   mul_a/mul_b. MUL gives the multiplier a full cycle to settle and then
//   captures mul_p. RESP holds the product behind a valid/ready port until it is
//   accepted or until ACK_TIMEOUT unaccepted cycles have passed.
//
//   Optional build macro: MULT_SHARE_FIXED_PRIO_EN
//     defined   -> requester 0 always wins contention
//     undefined -> round-robin on the last granted requester
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req{0,1}_valid/_a/_b/_ready   requester operand handshakes
//   mul_a, mul_b, mul_p           shared multiplier operands / product
//   rsp_valid/_ready/_p/_id       result handshake, product, owning requester
//   rsp_timeout                   1-cycle pulse when a result is dropped
//   busy                          registered "not IDLE"
module mult_share_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 15  // 0 disables the timeout
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_p,
  output logic       rsp_id,
  output logic       rsp_timeout,
  output logic       busy
);

  localparam int unsigned CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LIMIT = CW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_nxt;
  logic          grant0;
  logic          grant1;
  logic          accept;

`ifndef MULT_SHARE_FIXED_PRIO_EN
  logic          last_grant;
`endif

  // Requester 0 wins when it is alone, or in contention when requester 1 was
  // granted last (round-robin) / always (fixed priority).
  always_comb begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
    grant0 = req0_valid;
`else
    grant0 = req0_valid & (~req1_valid | last_grant);
`endif
    grant1 = req1_valid & ~grant0;
  end

  // Readies are combinational but masked by reset so nothing is accepted
  // while the block is held in reset.
  assign accept     = (state == IDLE) & rst_n;
  assign req0_ready = accept & grant0;
  assign req1_ready = accept & grant1;

  assign tmo_nxt = tmo_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_p       <= '0;
      rsp_id      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      tmo_cnt     <= '0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            mul_a      <= grant0 ? req0_a : req1_a;
            mul_b      <= grant0 ? req0_b : req1_b;
            rsp_id     <= grant1;
`ifndef MULT_SHARE_FIXED_PRIO_EN
            last_grant <= grant1;
`endif
            state      <= MUL;
            busy       <= 1'b1;
          end
        end
        MUL: begin
          rsp_p     <= mul_p;
          tmo_cnt   <= '0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Handshake has priority over a timeout landing on the same cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (ACK_TIMEOUT != 0) begin
            tmo_cnt <= tmo_nxt;
            if (tmo_nxt == TMO_LIMIT) begin
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios, an operand sweep and random
// traffic, checked against a transaction-level model (grant rule, a*b,
// acknowledge delay vs. timeout limit).
module tb_mult_share_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_p;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_timeout, busy;
  logic [7:0] rsp_p;

  int n_chk = 0;
  int n_err = 0;

  // Requester model: pending requests and the last granted requester.
  logic       v [2];
  logic [3:0] a [2];
  logic [3:0] b [2];
  int         last;

  always #5 clk = ~clk;

  // External shared multiplier.
  assign mul_p = 8'(mul_a) * 8'(mul_b);

  mult_share_ctrl #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req0_valid = v[0]; req0_a = a[0]; req0_b = b[0];
    req1_valid = v[1]; req1_a = a[1]; req1_b = b[1];
  endtask

  // Winner among the pending requests (at least one must be pending).
  function automatic int pick();
`ifdef MULT_SHARE_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    if (v[0] && v[1]) return (last == 1) ? 0 : 1;
    return v[0] ? 0 : 1;
`endif
  endfunction

  // One full transaction from IDLE; the consumer accepts after d RESP cycles.
  task automatic run_txn(input int d);
    int  w;
    int  exp_p;
    bit  hs;
    apply();
    #1;
    w     = pick();
    exp_p = int'(a[w]) * int'(b[w]);
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("busy_idle", busy, 0);
    tick();
    last = w;
    v[w] = 1'b0;   // winner retires its request, a loser keeps holding
    apply();
    chk("mul_busy", busy, 1);
    chk("mul_rsp_valid", rsp_valid, 0);
    chk("mul_timeout", rsp_timeout, 0);
    chk("mul_ready", {req0_ready, req1_ready}, 0);
    chk("mul_a", mul_a, a[w]);
    chk("mul_b", mul_b, b[w]);
    tick();
    hs = 1'b0;
    for (int k = 0; k < TMO && !hs; k++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_p", rsp_p, exp_p);
      chk("rsp_id", rsp_id, w);
      chk("rsp_no_ready", {req0_ready, req1_ready}, 0);
      rsp_ready = (k >= d);
      hs = rsp_ready;
      tick();
    end
    rsp_ready = 1'b0;
    chk("end_rsp_valid", rsp_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_timeout", rsp_timeout, d >= TMO);
    chk("end_rsp_p_hold", rsp_p, exp_p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] ab;
    last = 1;
    v[0] = 1'b1; v[1] = 1'b1;
    a[0] = 4'd3; b[0] = 4'd4; a[1] = 4'd5; b[1] = 4'd6;
    rst_n = 1'b0; rsp_ready = 1'b0;
    apply();
    #2;
    // Reset state, with both requesters already pushing.
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_mul", {mul_a, mul_b}, 0);
    chk("rst_rsp", {rsp_p, rsp_id}, 0);
    tick();
    rst_n = 1'b1;

    // First contention after reset grants requester 0, then alternation.
    for (int i = 0; i < 4; i++) begin
      v[0] = 1'b1; v[1] = 1'b1;
      run_txn(0);
`ifdef MULT_SHARE_FIXED_PRIO_EN
      chk("cont_id", rsp_id, 0);
`else
      chk("cont_id", rsp_id, i % 2);
`endif
    end

    // Single request with the maximum product.
    v[0] = 1'b1; v[1] = 1'b0; a[0] = 4'd15; b[0] = 4'd15;
    run_txn(0);

    // Backpressure, timeout, recovery, and handshake on the limit cycle.
    v[1] = 1'b1; a[1] = 4'd9; b[1] = 4'd7;
    run_txn(5);
    v[0] = 1'b1; a[0] = 4'd11; b[0] = 4'd13;
    run_txn(20);
    v[1] = 1'b1; a[1] = 4'd2; b[1] = 4'd14;
    run_txn(0);
    v[0] = 1'b1; a[0] = 4'd6; b[0] = 4'd10;
    run_txn(TMO - 1);

    // Reset while a result is pending in RESP.
    v[0] = 1'b1; v[1] = 1'b0; a[0] = 4'd7; b[0] = 4'd8;
    apply();
    tick();
    tick();
    chk("pre_rst_valid", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mul", {mul_a, mul_b}, 0);
    chk("arst_rsp", {rsp_p, rsp_id}, 0);
    chk("arst_ready", req0_ready, 0);
    tick();
    chk("arst_timeout", rsp_timeout, 0);
    rst_n = 1'b1;
    last = 1;
    v[0] = 1'b1; v[1] = 1'b1; a[1] = 4'd1; b[1] = 4'd1;
    run_txn(0);
    chk("post_rst_grant", rsp_id, 0);
    v[1] = 1'b1;
    run_txn(0);

    // All 256 operand pairs from alternating requesters.
    for (int i = 0; i < 256; i++) begin
      ab = 8'(i);
      v[i % 2] = 1'b1; v[1 - (i % 2)] = 1'b0;
      a[i % 2] = ab[7:4]; b[i % 2] = ab[3:0];
      run_txn(0);
    end

    // Random traffic: losers keep their request, idle gaps, random ack delay.
    v[0] = 1'b0; v[1] = 1'b0;
    for (int i = 0; i < 150; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r]) begin
          v[r] = 1'($urandom % 2);
          a[r] = 4'($urandom);
          b[r] = 4'($urandom);
        end
      end
      if (!v[0] && !v[1]) begin
        apply();
        #1;
        chk("idle_ready", {req0_ready, req1_ready}, 0);
        tick();
        chk("idle_busy", busy, 0);
        continue;
      end
      run_txn(int'($urandom_range(0, 17)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
